// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a load scoreboard.
// Reads and the stall decision are combinational. Register contents,
// pending-load bits and their count change on the rising clock edge.
//
// Issue handshake: decode raises issue_valid with a candidate instruction.
// While stall=1 decode must hold that instruction. The instruction is
// accepted on any rising edge where issue_valid=1, stall=0 and issue_kill=0.
// stall does not look at issue_kill, so a squashed instruction can still
// stall for the cycle in which it is presented.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int CW     = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    input  logic [NRD-1:0]      rs_used,
    output logic [NRD*XLEN-1:0] rs_data,
    input  logic                issue_valid,
    input  logic                issue_kill,
    input  logic                issue_load,
    input  logic [AW-1:0]       issue_rd,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic                stall,
    output logic [NREGS-1:0]    pend,
    output logic [CW-1:0]       pend_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_next;
    logic [CW-1:0]    cnt_next;
    logic [NRD-1:0]   hazard;
    logic             accept;

    // A real, writable register: nonzero and inside the implemented file.
    function automatic logic valid_reg(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREGS);
    endfunction

    // Per-port read data and hazard, with optional same-cycle writeback forwarding.
    always_comb begin
        rs_data = '0;
        hazard  = '0;
        for (int i = 0; i < NRD; i++) begin
            if (valid_reg(rs_addr[i*AW +: AW])) begin
                if ((BYPASS != 0) && wb_en && (wb_addr == rs_addr[i*AW +: AW])) begin
                    // Forwarded value arrives this cycle, so the pending load no longer blocks.
                    rs_data[i*XLEN +: XLEN] = wb_data;
                end else begin
                    rs_data[i*XLEN +: XLEN] = regs[rs_addr[i*AW +: AW]];
                    hazard[i] = rs_used[i] && pend_q[rs_addr[i*AW +: AW]];
                end
            end
        end
    end

    // Stall the issuing instruction on any operand hazard; compute acceptance.
    always_comb begin
        stall  = issue_valid && (|hazard);
        accept = issue_valid && !stall && !issue_kill;
    end

    // Next scoreboard value: writeback clears first, an accepted load sets last so it wins.
    always_comb begin
        pend_next = pend_q;
        if (wb_en && valid_reg(wb_addr)) begin
            pend_next[wb_addr] = 1'b0;
        end
        if (accept && issue_load && valid_reg(issue_rd)) begin
            pend_next[issue_rd] = 1'b1;
        end
    end

    // Population count of the next scoreboard value.
    always_comb begin
        cnt_next = '0;
        for (int k = 0; k < NREGS; k++) begin
            cnt_next = cnt_next + CW'(pend_next[k]);
        end
    end

    // Register storage: reset clears everything, writes to r0 or beyond NREGS are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                regs[k] <= '0;
            end
        end else if (wb_en && valid_reg(wb_addr)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard and its count; reset forgets every load in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            pend_cnt <= '0;
        end else begin
            pend_q   <= pend_next;
            pend_cnt <= cnt_next;
        end
    end

    assign pend = pend_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one forwarding instance (32 registers) and one
// non-forwarding instance (28 registers) driven by the same inputs.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  rs_addr;
    logic [1:0]  rs_used;
    logic        issue_valid, issue_kill, issue_load;
    logic [4:0]  issue_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic [63:0] rs_data_b1, rs_data_b0;
    logic        stall_b1, stall_b0;
    logic [31:0] pend_b1;
    logic [27:0] pend_b0;
    logic [5:0]  cnt_b1, cnt_b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    regfile_sb #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(1), .CW(6)) dut_b1 (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_used(rs_used), .rs_data(rs_data_b1),
        .issue_valid(issue_valid), .issue_kill(issue_kill), .issue_load(issue_load),
        .issue_rd(issue_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall_b1), .pend(pend_b1), .pend_cnt(cnt_b1)
    );

    regfile_sb #(.XLEN(32), .NREGS(28), .AW(5), .NRD(2), .BYPASS(0), .CW(6)) dut_b0 (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_used(rs_used), .rs_data(rs_data_b0),
        .issue_valid(issue_valid), .issue_kill(issue_kill), .issue_load(issue_load),
        .issue_rd(issue_rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall_b0), .pend(pend_b0), .pend_cnt(cnt_b0)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model (index 1 = forwarding, 0 = not) ----------------
    logic [31:0] m_regs [2][32];
    bit          m_pend [2][32];

    function automatic int m_nregs(input int d);
        return (d == 1) ? 32 : 28;
    endfunction

    function automatic bit m_fwd(input int d, input logic [4:0] a);
        return (d == 1) && wb_en && (wb_addr == a);
    endfunction

    function automatic logic [31:0] m_read(input int d, input logic [4:0] a);
        if (a == 0 || int'(a) >= m_nregs(d)) return 32'h0;
        if (m_fwd(d, a)) return wb_data;
        return m_regs[d][a];
    endfunction

    function automatic bit m_stall(input int d);
        bit any = 0;
        for (int p = 0; p < 2; p++) begin
            logic [4:0] a = rs_addr[p*5 +: 5];
            if (rs_used[p] && a != 0 && int'(a) < m_nregs(d) && m_pend[d][a] && !m_fwd(d, a))
                any = 1;
        end
        return issue_valid && any;
    endfunction

    function automatic logic [31:0] m_pend_vec(input int d);
        logic [31:0] v = '0;
        for (int r = 0; r < 32; r++) v[r] = m_pend[d][r];
        return v;
    endfunction

    function automatic int m_cnt(input int d);
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_pend[d][r]);
        return c;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic m_step();
        for (int d = 0; d < 2; d++) begin
            bit st = m_stall(d);
            int n  = m_nregs(d);
            if (rst) begin
                for (int r = 0; r < 32; r++) begin
                    m_regs[d][r] = 32'h0;
                    m_pend[d][r] = 0;
                end
            end else begin
                if (wb_en && wb_addr != 0 && int'(wb_addr) < n) begin
                    m_regs[d][wb_addr] = wb_data;
                    m_pend[d][wb_addr] = 0;
                end
                if (issue_valid && !st && !issue_kill && issue_load && issue_rd != 0 && int'(issue_rd) < n)
                    m_pend[d][issue_rd] = 1;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit r, input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] u,
                         input bit iv, input bit ik, input bit il, input logic [4:0] rd,
                         input bit we, input logic [4:0] wa, input logic [31:0] wd);
        rst = r; rs_addr = {a1, a0}; rs_used = u;
        issue_valid = iv; issue_kill = ik; issue_load = il; issue_rd = rd;
        wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          rst;
        logic [4:0]  rs0, rs1;
        logic [1:0]  used;
        bit          iv, ik, il;
        logic [4:0]  rd;
        bit          wbe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic [31:0] x0_b1, x0_b0, x1;
        bit          st_b1, st_b0;
        logic [5:0]  cnt;
    } vec_t;

    vec_t tbl [26];

    initial begin
        // rst rs0 rs1 used iv ik il rd wbe wba wbd | x0_b1 x0_b0 x1 st_b1 st_b0 cnt
        tbl[0]  = '{1, 0, 0, 0, 0,0,0, 0, 1, 3, 32'hFFFF,     0, 0, 0, 0,0, 0};
        tbl[1]  = '{0, 3, 0, 0, 0,0,0, 0, 0, 0, 0,            0, 0, 0, 0,0, 0};
        tbl[2]  = '{0, 5, 0, 0, 0,0,0, 0, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0,0, 0};
        tbl[3]  = '{0, 5, 0, 0, 0,0,0, 0, 1, 0, 32'h1234,     32'hDEADBEEF, 32'hDEADBEEF, 0, 0,0, 0};
        tbl[4]  = '{0, 0, 5, 0, 0,0,0, 0, 0, 0, 0,            0, 0, 32'hDEADBEEF, 0,0, 0};
        tbl[5]  = '{0, 7, 0, 0, 0,0,0, 0, 1, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0,0, 0};
        tbl[6]  = '{0, 7, 0, 0, 0,0,0, 0, 0, 0, 0,            32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0,0, 0};
        tbl[7]  = '{0, 0, 0, 0, 1,0,1, 9, 0, 0, 0,            0, 0, 0, 0,0, 0};
        tbl[8]  = '{0, 9, 0, 1, 1,0,0,10, 0, 0, 0,            0, 0, 0, 1,1, 1};
        tbl[9]  = '{0, 9, 0, 1, 1,0,0,10, 0, 0, 0,            0, 0, 0, 1,1, 1};
        tbl[10] = '{0, 9, 0, 1, 1,0,0,10, 1, 9, 32'h99,       32'h99, 0, 0, 0,1, 1};
        tbl[11] = '{0, 9, 0, 1, 1,0,0,10, 0, 0, 0,            32'h99, 32'h99, 0, 0,0, 0};
        tbl[12] = '{0, 0, 0, 0, 1,1,1, 4, 0, 0, 0,            0, 0, 0, 0,0, 0};
        tbl[13] = '{0, 4, 0, 1, 1,0,0, 0, 0, 0, 0,            0, 0, 0, 0,0, 0};
        tbl[14] = '{0, 0, 0, 0, 1,0,1, 6, 1, 6, 32'h66,       0, 0, 0, 0,0, 0};
        tbl[15] = '{0, 6, 0, 0, 1,0,0, 0, 0, 0, 0,            32'h66, 32'h66, 0, 0,0, 1};
        tbl[16] = '{0, 6, 0, 1, 1,0,0, 0, 0, 0, 0,            32'h66, 32'h66, 0, 1,1, 1};
        tbl[17] = '{0, 6, 0, 1, 0,0,0, 0, 1, 6, 32'h67,       32'h67, 32'h66, 0, 0,0, 1};
        tbl[18] = '{0, 0, 0, 0, 1,0,1, 1, 0, 0, 0,            0, 0, 0, 0,0, 0};
        tbl[19] = '{0, 0, 0, 0, 1,0,1, 2, 0, 0, 0,            0, 0, 0, 0,0, 1};
        tbl[20] = '{0, 0, 0, 0, 1,0,1, 3, 0, 0, 0,            0, 0, 0, 0,0, 2};
        tbl[21] = '{1, 3, 0, 1, 1,0,0, 0, 0, 0, 0,            0, 0, 0, 1,1, 3};
        tbl[22] = '{0, 3, 0, 1, 1,0,0, 0, 0, 0, 0,            0, 0, 0, 0,0, 0};
        tbl[23] = '{0, 5, 7, 0, 0,0,0, 0, 0, 0, 0,            0, 0, 0, 0,0, 0};
        tbl[24] = '{0,30, 0, 0, 0,0,0, 0, 1,30, 32'h30,       32'h30, 0, 0, 0,0, 0};
        tbl[25] = '{0,30, 0, 0, 0,0,0, 0, 0, 0, 0,            32'h30, 0, 0, 0,0, 0};
    end

    // ---------------- stimulus and checking ----------------
    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            m_step();
        end

        // Directed sequence with hand-derived expectations.
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            drive(tbl[k].rst, tbl[k].rs0, tbl[k].rs1, tbl[k].used, tbl[k].iv, tbl[k].ik,
                  tbl[k].il, tbl[k].rd, tbl[k].wbe, tbl[k].wba, tbl[k].wbd);
            #1;
            check($sformatf("v%0d rs0_b1", k), rs_data_b1[31:0],  tbl[k].x0_b1);
            check($sformatf("v%0d rs0_b0", k), rs_data_b0[31:0],  tbl[k].x0_b0);
            check($sformatf("v%0d rs1_b1", k), rs_data_b1[63:32], tbl[k].x1);
            check($sformatf("v%0d rs1_b0", k), rs_data_b0[63:32], tbl[k].x1);
            check($sformatf("v%0d stall_b1", k), 32'(stall_b1), 32'(tbl[k].st_b1));
            check($sformatf("v%0d stall_b0", k), 32'(stall_b0), 32'(tbl[k].st_b0));
            check($sformatf("v%0d cnt_b1", k), 32'(cnt_b1), 32'(tbl[k].cnt));
            check($sformatf("v%0d cnt_b0", k), 32'(cnt_b0), 32'(tbl[k].cnt));
            m_step();
        end

        // Randomised traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a [4];
            for (int j = 0; j < 4; j++)
                a[j] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 7));
            @(negedge clk);
            drive($urandom_range(0, 99) < 2, a[0], a[1], 2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, a[2],
                  $urandom_range(0, 9) < 4, a[3], $urandom);
            #1;
            for (int d = 1; d >= 0; d--) begin
                exp_q.push_back(m_read(d, rs_addr[4:0]));
                exp_q.push_back(m_read(d, rs_addr[9:5]));
                exp_q.push_back(32'(m_stall(d)));
                exp_q.push_back(m_pend_vec(d));
                exp_q.push_back(32'(m_cnt(d)));
            end
            check($sformatf("r%0d rs0_b1", n),   rs_data_b1[31:0],  exp_q.pop_front());
            check($sformatf("r%0d rs1_b1", n),   rs_data_b1[63:32], exp_q.pop_front());
            check($sformatf("r%0d stall_b1", n), 32'(stall_b1),     exp_q.pop_front());
            check($sformatf("r%0d pend_b1", n),  pend_b1,           exp_q.pop_front());
            check($sformatf("r%0d cnt_b1", n),   32'(cnt_b1),       exp_q.pop_front());
            check($sformatf("r%0d rs0_b0", n),   rs_data_b0[31:0],  exp_q.pop_front());
            check($sformatf("r%0d rs1_b0", n),   rs_data_b0[63:32], exp_q.pop_front());
            check($sformatf("r%0d stall_b0", n), 32'(stall_b0),     exp_q.pop_front());
            check($sformatf("r%0d pend_b0", n),  32'(pend_b0),      exp_q.pop_front());
            check($sformatf("r%0d cnt_b0", n),   32'(cnt_b0),       exp_q.pop_front());
            m_step();
        end

        // Final report
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file with integrated load scoreboard and hazard-stall generation for the pipelined RISC-V core.
- Replaces the fixed 2-read/32x32 register file and separate stall logic of the 3-stage pipeline.
- Configurable width, register count, read-port count and write-to-read bypass mode.
- Sits between decode (read/issue side) and memory/writeback (write side).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (register 0 hardwired to zero)
AW, 5, register address width; NREGS <= 2**AW
NRD, 2, number of read ports
BYPASS, 1, 1 = same-cycle writeback forwarded to reads and clears the hazard; 0 = no forwarding
CW, 6, width of pend_cnt; must hold NREGS-1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
rs_addr  input  NRD*AW  read addresses; port i at bits [i*AW +: AW]
rs_used  input  NRD  port i address is a real source operand
rs_data  output  NRD*XLEN  read data, combinational
issue_valid  input  1  decode presents an instruction this cycle
issue_kill  input  1  squash the issuing instruction (taken branch)
issue_load  input  1  issuing instruction is a load
issue_rd  input  AW  destination of issuing instruction
wb_en  input  1  writeback strobe
wb_addr  input  AW  writeback destination
wb_data  input  XLEN  writeback data
stall  output  1  decode must hold, combinational
pend  output  NREGS  per-register pending-load bits, registered
pend_cnt  output  CW  number of set pend bits, registered

Behaviour:
- Reset: on the clk edge with rst=1, all registers := 0, pend := 0, pend_cnt := 0. rst overrides every other input that cycle, including wb_en and issue; a load in flight at reset is forgotten, and its later writeback still writes the register.
- Reads, port i, combinational:
  - rs_addr = 0 -> 0.
  - BYPASS=1, wb_en=1 and wb_addr = rs_addr (nonzero) -> wb_data.
  - otherwise -> stored value.
  - Address >= NREGS -> 0.
- Writes: on the edge with wb_en=1 and wb_addr nonzero and < NREGS, reg[wb_addr] := wb_data. Writes to 0 or out-of-range addresses are ignored.
- Hazard for port i, combinational: rs_used[i]=1, rs_addr[i] nonzero, and pend[rs_addr[i]]=1.
  - BYPASS=1: the hazard is masked when wb_en=1 and wb_addr = rs_addr[i] in the same cycle.
  - BYPASS=0: never masked; stall therefore persists one extra cycle after the writeback.
- stall = issue_valid AND (OR of all port hazards). stall does not depend on issue_kill.
- Accepted issue = issue_valid AND NOT stall AND NOT issue_kill.
- Scoreboard update on the edge (rst=0):
  - Clear: wb_en=1 -> pend[wb_addr] := 0.
  - Set: accepted issue with issue_load=1 and issue_rd nonzero, < NREGS -> pend[issue_rd] := 1.
  - Same register set and cleared in one cycle: set wins (new load outstanding).
  - Writeback to a non-pending register: no scoreboard effect.
- pend_cnt: registered popcount of the next pend value, updated on the same edge. Range 0..NREGS-1; no wrap.
- Latency:
  - Read: 0 cycles.
  - Write visible to non-bypassed reads: next cycle.
  - pend / pend_cnt: 1 cycle after the cause.
  - stall deasserts in the writeback cycle (BYPASS=1) or the cycle after it (BYPASS=0).
- Non-load issues never touch the scoreboard. A second load to an already-pending register keeps the bit set.

Test Plan:
- Reset then read: rst=1 for 1 cycle with wb_en=1, wb_addr=3 -> reg3 stays 0; rs_data all 0, pend=0, pend_cnt=0.
- Write/read and x0: write 0xDEADBEEF to r5, then 0x1234 to r0; next cycle read r5, r0 -> 0xDEADBEEF, 0.
- BYPASS=1 same-cycle forwarding: wb r7=0xA5A5A5A5 while reading r7 -> rs_data = 0xA5A5A5A5 that cycle.
- BYPASS=0 same-cycle read: same stimulus -> old value returned.
- Load-use stall, BYPASS=1:
  - Issue load rd=9 at cycle 0 -> pend[9]=1, pend_cnt=1 at cycle 1.
  - Consumer with rs_addr0=9 used -> stall=1 while pending.
  - wb r9 at cycle 3 -> stall=0 in cycle 3 with forwarded data; pend_cnt=0 at cycle 4.
- Load-use stall, BYPASS=0: same sequence -> stall=1 through cycle 3, 0 at cycle 4.
- Kill and collision:
  - Load rd=4 with issue_kill=1 -> pend[4] stays 0.
  - Load rd=6 issued in the same cycle as wb r6 -> pend[6]=1 afterwards.
  - Unused port (rs_used=0) addressing pending r6 -> stall=0.
- Reset mid-operation: loads to r1, r2, r3 pending (pend_cnt=3), then rst -> pend=0, pend_cnt=0, stall=0 next cycle.
